// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The default reset vector also feeds the reset vector logic elsewhere in the core.
package ifu_pkg;

  localparam logic [29:0] DEFAULT_RESET_PC = 30'h0000_0C00;

  typedef enum logic {
    S_RUN,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] data;
    logic        dv;
  } entry_t;

endpackage

// File: rtl/ifu_queue.sv
// In-order fetch buffer: entries are allocated at grant time and filled by
// responses in request order, so the oldest unfilled entry is tracked by r_fl.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [29:0]              push_pc,
  input  logic                     fill,
  input  logic [31:0]              fill_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   n_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_fl;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_pend;
  logic            w_fill_ok;

  // A fill with nothing awaiting data is a protocol error and is dropped here.
  assign w_fill_ok = fill && (r_pend != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_fl    <= '0;
      r_count <= '0;
      r_pend  <= '0;
    end else begin
      // Clearing dv on pop keeps a recycled slot from looking valid at the head.
      if (pop) begin
        r_mem[r_rd].dv <= 1'b0;
        r_rd           <= r_rd + 1'b1;
      end
      if (push) begin
        r_mem[r_wr] <= '{pc: push_pc, data: 32'h0, dv: 1'b0};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_fill_ok) begin
        r_mem[r_fl].data <= fill_data;
        r_mem[r_fl].dv   <= 1'b1;
        r_fl             <= r_fl + 1'b1;
      end
      r_count <= r_count + CW'(push) - CW'(pop);
      r_pend  <= r_pend + CW'(push) - CW'(w_fill_ok);
    end
  end

  assign count     = r_count;
  assign head      = r_mem[r_rd];
  assign n_pending = r_pend;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues word fetches, buffers
// responses in order and discards stale responses after a redirect.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [29:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [29:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t          r_state;
  state_t          w_state_n;
  logic [29:0]     r_fpc;
  logic [29:0]     w_fpc_n;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   w_drop_n;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_pending;
  entry_t          w_head;
  logic            w_push;
  logic            w_fill;
  logic            w_pop;

  assign imem_req  = !rst && (r_state == S_RUN) && (w_count < CW'(DEPTH)) && !redirect_valid;
  assign imem_addr = r_fpc;
  assign w_push    = imem_req && imem_gnt;
  assign w_fill    = imem_rvalid && (r_state == S_RUN) && !redirect_valid;
  assign w_pop     = w_head.dv && inst_ready;

  assign inst_valid = w_head.dv;
  assign inst       = w_head.data;
  assign inst_pc    = w_head.pc;

  ifu_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_pc   (r_fpc),
    .fill      (w_fill),
    .fill_data (imem_rdata),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .count     (w_count),
    .head      (w_head),
    .n_pending (w_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_fpc   <= RESET_PC;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_n;
      r_fpc   <= w_fpc_n;
      r_drop  <= w_drop_n;
    end
  end

  // Every unfilled entry at redirect time still has a response in flight;
  // one arriving in the redirect cycle itself is already accounted for.
  always_comb begin
    w_state_n = r_state;
    w_fpc_n   = r_fpc;
    w_drop_n  = r_drop;
    if (redirect_valid) begin
      w_fpc_n = redirect_pc;
      if (r_state == S_RUN)
        w_drop_n = w_pending - CW'(imem_rvalid && (w_pending != '0));
      else
        w_drop_n = r_drop - CW'(imem_rvalid && (r_drop != '0));
      w_state_n = (w_drop_n != '0) ? S_DRAIN : S_RUN;
    end else if (r_state == S_DRAIN) begin
      if (imem_rvalid && (r_drop != '0))
        w_drop_n = r_drop - 1'b1;
      if (w_drop_n == '0)
        w_state_n = S_RUN;
    end else if (w_push) begin
      w_fpc_n = r_fpc + 30'd1;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    (imem_rvalid && (r_state == S_RUN) && !redirect_valid) |-> (w_pending != '0));

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: stimulus pushes expected PCs, a memory model
// answers grants, and a monitor checks every instruction handed to decode.
module tb_ifu;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [29:0] redirect_pc = '0;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [29:0] inst_pc;
  logic        inst_ready = 1'b0;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] due;
  } memTxn_t;

  int          checks = 0;
  int          failures = 0;
  int          budget = 0;
  int          cyc = 0;
  bit          memHold = 1'b0;
  memTxn_t     memQ[$];
  memTxn_t     memTxn;
  logic [29:0] grantLog[$];
  logic [29:0] expQ[$];
  logic [29:0] monExp;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(30'h0000_0C00), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  function automatic logic [31:0] memData(input logic [29:0] a);
    return {a, 2'b00} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic redir, input logic [29:0] rpc, input logic ready);
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = ready;
  endtask

  task automatic expectRange(input logic [29:0] start, input int n);
    for (int i = 0; i < n; i++) expQ.push_back(start + 30'(i));
  endtask

  task automatic checkGrant(input string name, input int idx, input logic [29:0] expected);
    if (idx < grantLog.size()) begin
      checkOutput(name, {2'b00, grantLog[idx]}, {2'b00, expected});
    end else begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got no grant, expected 0x%08h", name, expected);
    end
  endtask

  task automatic waitIdle(input string name, input int maxCyc);
    int n = 0;
    while (n < maxCyc && !(expQ.size() == 0 && memQ.size() == 0 && budget == 0)) begin
      nextCycle();
      n++;
    end
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  task automatic waitGrants(input string name, input int target, input int maxCyc);
    int n = 0;
    while (n < maxCyc && grantLog.size() < target) begin
      nextCycle();
      n++;
    end
    checkOutput(name, 32'(grantLog.size()), 32'(target));
  endtask

  // Memory model: grants while budget lasts, answers in order one cycle
  // after grant unless held, and forgets everything while reset is high.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      memQ.delete();
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (!memHold && memQ.size() > 0 && memQ[0].due <= 32'(cyc)) begin
        memTxn      = memQ.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = memData(memTxn.addr);
      end
      imem_gnt = (budget > 0);
      #1;
      if (!rst && imem_req && imem_gnt) begin
        memTxn.addr = imem_addr;
        memTxn.due  = 32'(cyc + 1);
        memQ.push_back(memTxn);
        grantLog.push_back(imem_addr);
        budget--;
      end
    end
  end

  // Monitor: every accepted instruction must be the next expected PC with its data.
  always @(negedge clk) begin
    #1;
    if (!rst && inst_valid && inst_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedInst: got pc 0x%08h, expected none", inst_pc);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("instPc", {2'b00, inst_pc}, {2'b00, monExp});
        checkOutput("instData", inst, memData(monExp));
      end
    end
  end

  initial begin
    int base;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    #1;
    checkOutput("rstInstValid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rstInst", inst, 32'd0);
    checkOutput("rstInstPc", {2'b00, inst_pc}, 32'd0);
    checkOutput("rstReq", {31'd0, imem_req}, 32'd0);

    // Stream from the reset vector.
    budget = 8;
    inst_ready = 1'b1;
    expectRange(30'h0000_0C00, 8);
    rst = 1'b0;
    #1;
    checkOutput("firstReq", {31'd0, imem_req}, 32'd1);
    checkOutput("firstAddr", {2'b00, imem_addr}, 32'h0000_0C00);
    waitIdle("streamDrain", 60);
    #1;
    checkOutput("idleAddr", {2'b00, imem_addr}, 32'h0000_0C08);
    checkOutput("idleReq", {31'd0, imem_req}, 32'd1);

    // Backpressure: only two fetches may be in flight or buffered.
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0);
    base = grantLog.size();
    budget = 5;
    repeat (8) nextCycle();
    #1;
    checkOutput("bpGrants", 32'(grantLog.size() - base), 32'd2);
    checkOutput("bpReqLow", {31'd0, imem_req}, 32'd0);
    checkOutput("bpHeadValid", {31'd0, inst_valid}, 32'd1);
    checkOutput("bpHeadPc", {2'b00, inst_pc}, 32'h0000_0C08);
    expectRange(30'h0000_0C08, 5);
    inst_ready = 1'b1;
    waitIdle("bpDrain", 60);

    // Redirect with two responses outstanding.
    nextCycle();
    memHold = 1'b1;
    budget = 2;
    base = grantLog.size();
    waitGrants("twoOutstanding", base + 2, 20);
    nextCycle();
    applyStimulus(1'b1, 30'h0000_1000, 1'b1);
    #1;
    checkOutput("redirReqLow", {31'd0, imem_req}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("drainReqLow", {31'd0, imem_req}, 32'd0);
    checkOutput("drainInstValid", {31'd0, inst_valid}, 32'd0);
    base = grantLog.size();
    budget = 3;
    expectRange(30'h0000_1000, 3);
    memHold = 1'b0;
    waitIdle("redirDrain", 40);
    checkGrant("redirFirstReq", base, 30'h0000_1000);

    // Redirect in the same cycle as the only outstanding response.
    nextCycle();
    memHold = 1'b1;
    budget = 1;
    base = grantLog.size();
    waitGrants("oneOutstanding", base + 1, 20);
    nextCycle();
    memHold = 1'b0;
    applyStimulus(1'b1, 30'h0000_2000, 1'b1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("coincidentReq", {31'd0, imem_req}, 32'd1);
    checkOutput("coincidentAddr", {2'b00, imem_addr}, 32'h0000_2000);
    base = grantLog.size();
    budget = 2;
    expectRange(30'h0000_2000, 2);
    waitIdle("coincidentDrain", 30);
    checkGrant("coincidentFirstReq", base, 30'h0000_2000);

    // Fetch address wraps at the top of the 30-bit word space.
    nextCycle();
    applyStimulus(1'b1, 30'h3FFF_FFFF, 1'b1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1);
    #1;
    checkOutput("wrapStartAddr", {2'b00, imem_addr}, 32'h3FFF_FFFF);
    base = grantLog.size();
    budget = 2;
    expectRange(30'h3FFF_FFFF, 2);
    waitIdle("wrapDrain", 30);
    checkGrant("wrapFirst", base, 30'h3FFF_FFFF);
    checkGrant("wrapSecond", base + 1, 30'h0000_0000);
    #1;
    checkOutput("wrapIdleAddr", {2'b00, imem_addr}, 32'h0000_0001);

    // Reset in the middle of a stream, then restart from the reset vector.
    nextCycle();
    budget = 20;
    expectRange(30'h0000_0001, 20);
    repeat (6) nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("midRstInstValid", {31'd0, inst_valid}, 32'd0);
    checkOutput("midRstInst", inst, 32'd0);
    checkOutput("midRstInstPc", {2'b00, inst_pc}, 32'd0);
    checkOutput("midRstReq", {31'd0, imem_req}, 32'd0);
    checkOutput("midRstAddr", {2'b00, imem_addr}, 32'h0000_0C00);
    budget = 0;
    expQ.delete();
    repeat (2) nextCycle();
    base = grantLog.size();
    budget = 3;
    expectRange(30'h0000_0C00, 3);
    rst = 1'b0;
    #1;
    checkOutput("restartReq", {31'd0, imem_req}, 32'd1);
    checkOutput("restartAddr", {2'b00, imem_addr}, 32'h0000_0C00);
    waitIdle("restartDrain", 30);
    checkGrant("restartFirstReq", base, 30'h0000_0C00);

    repeat (2) nextCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
